mem_stage_sramlike: RTL

Memory-access pipeline stage for the 5-stage MIPS core, placed between EXE and WB, fed by a data bus with a request/response (addr_ok/data_ok) handshake instead of a fixed-latency SRAM. It holds a load in MEM until its response arrives and extracts lb/lbu/lh/lhu/lw/lwl/lwr results. It tracks in-flight requests and drops responses that belong to instructions killed by an exception flush. It also drives the MEM-to-ID bypass with a result-ready qualifier for load-use stalls.

---
 rtl/mem_stage_sramlike.sv | 261 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_stage_sramlike.sv
`default_nettype none
// ============================================================================
// Module   : mem_stage_sramlike
// Purpose  : MEM pipeline stage for the 5-stage MIPS core on a request /
//            response (addr_ok / data_ok) data bus. Holds a load until its
//            response arrives, extracts sub-word load results, tracks the
//            number of requests in flight and drops responses that belong
//            to instructions killed by a flush. Drives the MEM->ID bypass
//            with a ready qualifier for load-use stalls.
// Options  : define MS_UNALIGNED_LOAD_EN to enable the lwl/lwr merge; when
//            undefined, lwl/lwr return the raw response word like lw.
// Revision : 1.0 - initial release
// ============================================================================
module mem_stage_sramlike #(
    parameter int SIDE_WD         = 64,
    parameter int MAX_OUTSTANDING = 2,
    parameter int CNT_WD          = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               es_to_ms_valid,
    output logic               ms_allowin,
    input  logic               es_req_fire,
    input  logic               es_mem_req,
    input  logic [2:0]         es_load_op,
    input  logic               es_res_from_mem,
    input  logic               es_gr_we,
    input  logic [4:0]         es_dest,
    input  logic [31:0]        es_alu_result,
    input  logic [31:0]        es_rt_value,
    input  logic [SIDE_WD-1:0] es_side,
    input  logic               data_data_ok,
    input  logic [31:0]        data_rdata,
    input  logic               flush,
    input  logic               ws_allowin,
    output logic               ms_to_ws_valid,
    output logic               ms_gr_we,
    output logic [4:0]         ms_dest,
    output logic [31:0]        ms_result,
    output logic [SIDE_WD-1:0] ms_side,
    output logic [4:0]         ms_fwd_dest,
    output logic [31:0]        ms_fwd_result,
    output logic               ms_fwd_ready,
    output logic               ms_req_allow,
    output logic               ms_discard_busy
);

    localparam logic [2:0] c_OP_LW  = 3'd0;
    localparam logic [2:0] c_OP_LB  = 3'd1;
    localparam logic [2:0] c_OP_LBU = 3'd2;
    localparam logic [2:0] c_OP_LH  = 3'd3;
    localparam logic [2:0] c_OP_LHU = 3'd4;
`ifdef MS_UNALIGNED_LOAD_EN
    localparam logic [2:0] c_OP_LWL = 3'd5;
    localparam logic [2:0] c_OP_LWR = 3'd6;
`endif

    // Stage state
    logic               ms_valid_q,     ms_valid_d;
    logic               gr_we_q,        gr_we_d;
    logic [4:0]         dest_q,         dest_d;
    logic [31:0]        alu_result_q,   alu_result_d;
    logic [2:0]         load_op_q,      load_op_d;
    logic               res_from_mem_q, res_from_mem_d;
    logic [SIDE_WD-1:0] side_q,         side_d;
    logic               need_data_q,    need_data_d;
    logic               data_seen_q,    data_seen_d;
    logic [31:0]        rdata_q,        rdata_d;
    logic               early_v_q,      early_v_d;
    logic [31:0]        early_data_q,   early_data_d;
    logic [CNT_WD-1:0]  outstanding_q,  outstanding_d;
    logic [CNT_WD-1:0]  discard_q,      discard_d;
`ifdef MS_UNALIGNED_LOAD_EN
    logic [31:0]        rt_value_q,     rt_value_d;
`else
    logic               w_unused_rt;
    assign w_unused_rt = ^es_rt_value;
`endif

    logic              w_discard_hit;
    logic              w_consume;
    logic              w_to_early;
    logic              w_ready_go;
    logic              w_accept;
    logic [CNT_WD-1:0] w_out_next;
    logic [31:0]       w_rdata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_load;

    // Response routing: pending discards first, then the waiting load, else the early buffer.
    assign w_discard_hit = data_data_ok && (discard_q != '0);
    assign w_consume     = data_data_ok && !w_discard_hit && ms_valid_q && need_data_q && !data_seen_q;
    assign w_to_early    = data_data_ok && !w_discard_hit && !w_consume;
    assign w_ready_go    = !need_data_q || data_seen_q || w_consume;
    assign ms_allowin    = !ms_valid_q || (w_ready_go && ws_allowin);
    assign w_accept      = es_to_ms_valid && ms_allowin && !flush;
    assign w_out_next    = outstanding_q + CNT_WD'(es_req_fire) - CNT_WD'(data_data_ok);

    // Next-state computation for the stage registers and the bus counters.
    always_comb begin
        ms_valid_d     = ms_valid_q;
        gr_we_d        = gr_we_q;
        dest_d         = dest_q;
        alu_result_d   = alu_result_q;
        load_op_d      = load_op_q;
        res_from_mem_d = res_from_mem_q;
        side_d         = side_q;
        need_data_d    = need_data_q;
        data_seen_d    = data_seen_q;
        rdata_d        = rdata_q;
        early_v_d      = early_v_q;
        early_data_d   = early_data_q;
        outstanding_d  = w_out_next;
        discard_d      = discard_q;
`ifdef MS_UNALIGNED_LOAD_EN
        rt_value_d     = rt_value_q;
`endif
        if (flush) begin
            // Every request still in flight after this edge belongs to a killed instruction.
            ms_valid_d  = 1'b0;
            need_data_d = 1'b0;
            data_seen_d = 1'b0;
            early_v_d   = 1'b0;
            discard_d   = w_out_next;
        end else begin
            discard_d = discard_q - CNT_WD'(w_discard_hit);
            if (w_consume) begin
                rdata_d     = data_rdata;
                data_seen_d = 1'b1;
            end
            if (w_to_early) begin
                early_v_d    = 1'b1;
                early_data_d = data_rdata;
            end
            if (ms_allowin) begin
                ms_valid_d = es_to_ms_valid;
            end
            if (w_accept) begin
                gr_we_d        = es_gr_we;
                dest_d         = es_dest;
                alu_result_d   = es_alu_result;
                load_op_d      = es_load_op;
                res_from_mem_d = es_res_from_mem;
                side_d         = es_side;
`ifdef MS_UNALIGNED_LOAD_EN
                rt_value_d     = es_rt_value;
`endif
                need_data_d    = es_mem_req;
                data_seen_d    = 1'b0;
                if (es_mem_req) begin
                    if (early_v_q) begin
                        // Oldest buffered response belongs to the entering instruction;
                        // a response arriving now refills the buffer.
                        data_seen_d = 1'b1;
                        rdata_d     = early_data_q;
                        early_v_d   = w_to_early;
                    end else if (w_to_early) begin
                        // Response arriving in the very cycle its load enters: take it
                        // directly, otherwise it would be stranded in the early buffer.
                        data_seen_d = 1'b1;
                        rdata_d     = data_rdata;
                        early_v_d   = 1'b0;
                    end
                end
            end
        end
    end

    // Stage register update with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q     <= 1'b0;
            gr_we_q        <= 1'b0;
            dest_q         <= '0;
            alu_result_q   <= '0;
            load_op_q      <= '0;
            res_from_mem_q <= 1'b0;
            side_q         <= '0;
            need_data_q    <= 1'b0;
            data_seen_q    <= 1'b0;
            rdata_q        <= '0;
            early_v_q      <= 1'b0;
            early_data_q   <= '0;
            outstanding_q  <= '0;
            discard_q      <= '0;
`ifdef MS_UNALIGNED_LOAD_EN
            rt_value_q     <= '0;
`endif
        end else begin
            ms_valid_q     <= ms_valid_d;
            gr_we_q        <= gr_we_d;
            dest_q         <= dest_d;
            alu_result_q   <= alu_result_d;
            load_op_q      <= load_op_d;
            res_from_mem_q <= res_from_mem_d;
            side_q         <= side_d;
            need_data_q    <= need_data_d;
            data_seen_q    <= data_seen_d;
            rdata_q        <= rdata_d;
            early_v_q      <= early_v_d;
            early_data_q   <= early_data_d;
            outstanding_q  <= outstanding_d;
            discard_q      <= discard_d;
`ifdef MS_UNALIGNED_LOAD_EN
            rt_value_q     <= rt_value_d;
`endif
        end
    end

    // Load data extraction; a response consumed this cycle bypasses the data register.
    always_comb begin
        w_rdata = w_consume ? data_rdata : rdata_q;
        case (alu_result_q[1:0])
            2'd0:    w_byte = w_rdata[7:0];
            2'd1:    w_byte = w_rdata[15:8];
            2'd2:    w_byte = w_rdata[23:16];
            default: w_byte = w_rdata[31:24];
        endcase
        w_half = alu_result_q[1] ? w_rdata[31:16] : w_rdata[15:0];
        case (load_op_q)
            c_OP_LW:  w_load = w_rdata;
            c_OP_LB:  w_load = {{24{w_byte[7]}}, w_byte};
            c_OP_LBU: w_load = {24'd0, w_byte};
            c_OP_LH:  w_load = {{16{w_half[15]}}, w_half};
            c_OP_LHU: w_load = {16'd0, w_half};
`ifdef MS_UNALIGNED_LOAD_EN
            c_OP_LWL: begin
                case (alu_result_q[1:0])
                    2'd0:    w_load = {w_rdata[7:0],  rt_value_q[23:0]};
                    2'd1:    w_load = {w_rdata[15:0], rt_value_q[15:0]};
                    2'd2:    w_load = {w_rdata[23:0], rt_value_q[7:0]};
                    default: w_load = w_rdata;
                endcase
            end
            c_OP_LWR: begin
                case (alu_result_q[1:0])
                    2'd0:    w_load = w_rdata;
                    2'd1:    w_load = {rt_value_q[31:24], w_rdata[31:8]};
                    2'd2:    w_load = {rt_value_q[31:16], w_rdata[31:16]};
                    default: w_load = {rt_value_q[31:8],  w_rdata[31:24]};
                endcase
            end
`endif
            default:  w_load = w_rdata;
        endcase
    end

    assign ms_to_ws_valid  = ms_valid_q && w_ready_go;
    assign ms_gr_we        = gr_we_q;
    assign ms_dest         = dest_q;
    assign ms_side         = side_q;
    assign ms_result       = res_from_mem_q ? w_load : alu_result_q;
    assign ms_fwd_dest     = (ms_valid_q && gr_we_q) ? dest_q : 5'd0;
    assign ms_fwd_result   = ms_result;
    assign ms_fwd_ready    = !ms_valid_q || w_ready_go;
    assign ms_req_allow    = outstanding_q < CNT_WD'(MAX_OUTSTANDING);
    assign ms_discard_busy = discard_q != '0;

endmodule
`default_nettype wire
